memory_responder: RTL

Word-addressed memory that answers the controller's MAR/MDR/MemMode requests. It is the slave side of the memory interface: it accepts read and write commands, models a fixed access latency, and returns a one-cycle completion strobe. On reads it also returns data destined for the MDR. It sits between the control FSM's memory-phase states (load, store, and instruction fetch) and the data path.

---
 rtl/memory_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/memory_responder.sv
// Word-addressed memory slave answering MAR/MDR/MemMode requests with a fixed
// access latency. Define MEM_BOUNDS_EN to enable the out-of-range check and MemErr.
module memory_responder #(
  parameter int unsigned DEPTH   = 65536,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        MemMode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              MemBusy,
  output logic              MemReady,
  output logic              MemErr
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              commit;
  logic              in_range;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;

  logic [15:0] mem [DEPTH];

  // Effective address is the latched address modulo DEPTH (its low bits).
  assign idx = addr_q[IDX_W-1:0];

`ifdef MEM_BOUNDS_EN
  logic err_q, err_d;

  assign in_range = (32'(addr_q) < DEPTH);
  assign MemErr   = err_q;
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^addr_q;
  assign in_range       = 1'b1;
  assign MemErr         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
`ifdef MEM_BOUNDS_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (MemMode == 2'b01 || MemMode == 2'b10) begin
          addr_d  = addr;
          wdata_d = wdata;
          wr_d    = MemMode[1];
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = S_RESP;
          if (!wr_q) begin
            rdata_d = in_range ? mem[idx] : 16'h0000;
          end
`ifdef MEM_BOUNDS_EN
          err_d = !in_range;
`endif
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_BOUNDS_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
`ifdef MEM_BOUNDS_EN
      err_q   <= err_d;
`endif
    end
  end

  // Storage has no reset; a reset on the commit edge suppresses the store.
  assign mem_we = commit && wr_q && in_range;

  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  assign rdata    = rdata_q;
  assign MemBusy  = (state_q == S_WAIT);
  assign MemReady = (state_q == S_RESP);

endmodule
